// File: rtl/lathe_star_delta_seq.sv
// Star-delta spindle starter: sequences main/star/delta contactors with interlock,
// break-before-make dead time, main-contactor feedback supervision and a latched fault path.
module lathe_star_delta_seq #(
    parameter int unsigned CW         = 28,
    parameter int unsigned STAR_TIME  = 250_000_000,
    parameter int unsigned DEADTIME   = 2_500_000,
    parameter int unsigned FB_TIMEOUT = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       run_req,
    input  logic       estop,
    input  logic       ovl_trip,
    input  logic       main_fb,
    input  logic       fault_clr,
    output logic       k_main,
    output logic       k_star,
    output logic       k_delta,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STAR  = 3'd1,
        S_DEAD  = 3'd2,
        S_DELTA = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [CW-1:0] STAR_LAST = CW'(STAR_TIME - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEADTIME - 1);
    localparam logic [CW-1:0] FB_LIM    = CW'(FB_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]    code_q, code_d;
    logic          k_main_q, k_star_q, k_delta_q, fault_q;
    logic          fault_hit;
    logic [1:0]    fault_hit_code;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        code_d         = code_q;
        fault_hit      = 1'b0;
        fault_hit_code = 2'd0;
        cnt_inc        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

        // Fault supervision runs in every state except FAULT; estop wins over overload over feedback.
        if (state_q != S_FAULT) begin
            if (estop) begin
                fault_hit      = 1'b1;
                fault_hit_code = 2'd1;
            end else if (ovl_trip) begin
                fault_hit      = 1'b1;
                fault_hit_code = 2'd2;
            end else if (((state_q == S_STAR) && (cnt_q >= FB_LIM) && !main_fb) ||
                         (((state_q == S_DEAD) || (state_q == S_DELTA)) && !main_fb)) begin
                fault_hit      = 1'b1;
                fault_hit_code = 2'd3;
            end
        end

        if (fault_hit) begin
            state_d = S_FAULT;
            cnt_d   = '0;
            code_d  = fault_hit_code;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (run_req) state_d = S_STAR;
                end
                S_STAR: begin
                    if (!run_req) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == STAR_LAST) begin
                        state_d = S_DEAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_DEAD: begin
                    if (!run_req) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DEAD_LAST) begin
                        state_d = S_DELTA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_DELTA: begin
                    cnt_d = '0;
                    if (!run_req) state_d = S_IDLE;
                end
                S_FAULT: begin
                    cnt_d = '0;
                    // Leaving FAULT needs an explicit ack with every cause gone and no pending run.
                    if (fault_clr && !estop && !ovl_trip && !run_req) begin
                        state_d = S_IDLE;
                        code_d  = 2'd0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    code_d  = 2'd0;
                end
            endcase
        end
    end

    // Coils are decoded from the next state so they change on the same edge as state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            code_q    <= 2'd0;
            k_main_q  <= 1'b0;
            k_star_q  <= 1'b0;
            k_delta_q <= 1'b0;
            fault_q   <= 1'b0;
        end else if (ena) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            k_main_q  <= (state_d == S_STAR) || (state_d == S_DEAD) || (state_d == S_DELTA);
            k_star_q  <= (state_d == S_STAR);
            k_delta_q <= (state_d == S_DELTA);
            fault_q   <= (state_d == S_FAULT);
        end
    end

    assign k_main     = k_main_q;
    assign k_star     = k_star_q;
    assign k_delta    = k_delta_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_lathe_star_delta_seq.sv
// Scoreboard bench for the star-delta starter: the driver queues hand-derived expected
// state/fault code per cycle, the monitor checks them one clock edge later.
module tb_lathe_star_delta_seq;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] STAR  = 3'd1;
    localparam logic [2:0] DEAD  = 3'd2;
    localparam logic [2:0] DELTA = 3'd3;
    localparam logic [2:0] FLT   = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       run_req = 1'b0;
    logic       estop = 1'b0;
    logic       ovl_trip = 1'b0;
    logic       main_fb = 1'b1;
    logic       fault_clr = 1'b0;
    logic       k_main, k_star, k_delta, fault;
    logic [1:0] fault_code;
    logic [2:0] state_o;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] code;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    lathe_star_delta_seq #(
        .CW(28), .STAR_TIME(20), .DEADTIME(4), .FB_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .run_req(run_req), .estop(estop),
        .ovl_trip(ovl_trip), .main_fb(main_fb), .fault_clr(fault_clr),
        .k_main(k_main), .k_star(k_star), .k_delta(k_delta), .fault(fault),
        .fault_code(fault_code), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Coil pattern {main,star,delta,fault} for each state, from the output table.
    function automatic logic [3:0] coils(input logic [2:0] st);
        case (st)
            STAR:    coils = 4'b1100;
            DEAD:    coils = 4'b1000;
            DELTA:   coils = 4'b1010;
            FLT:     coils = 4'b0001;
            default: coils = 4'b0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    task automatic check_all(input exp_t e);
        check("state",  {1'b0, state_o}, {1'b0, e.st});
        check("coils",  {k_main, k_star, k_delta, fault}, coils(e.st));
        check("code",   {2'b00, fault_code}, {2'b00, e.code});
        check("interlock", {3'b000, k_star & k_delta}, 4'h0);
        $display("t=%0t state=%0d coils=%b code=%0d", $time, state_o,
                 {k_main, k_star, k_delta, fault}, fault_code);
    endtask

    // Monitor: compares one queued expectation shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_all(e);
            end
        end
    end

    task automatic tick(input logic [2:0] st, input logic [1:0] code = 2'd0);
        exp_t e;
        e.st   = st;
        e.code = code;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_to_delta();
        run_req = 1'b1;
        repeat (20) tick(STAR);
        repeat (4)  tick(DEAD);
        tick(DELTA);
    endtask

    task automatic clear_fault();
        estop = 1'b0; ovl_trip = 1'b0; run_req = 1'b0; main_fb = 1'b1; fault_clr = 1'b1;
        tick(IDLE);
        fault_clr = 1'b0;
    endtask

    initial begin
        exp_t e0;
        #3;
        e0 = '0;
        check_all(e0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(IDLE);

        // Normal start, then stop from DELTA.
        run_to_delta();
        repeat (2) tick(DELTA);
        run_req = 1'b0;
        repeat (2) tick(IDLE);

        // Stop mid-STAR and restart from a full STAR.
        run_req = 1'b1;
        repeat (11) tick(STAR);
        run_req = 1'b0;
        tick(IDLE);
        run_to_delta();
        run_req = 1'b0;
        tick(IDLE);

        // Feedback never arrives after STAR entry.
        main_fb = 1'b0;
        run_req = 1'b1;
        repeat (9) tick(STAR);
        tick(FLT, 2'd3);
        tick(FLT, 2'd3);
        clear_fault();

        // Feedback lost in DELTA.
        run_to_delta();
        main_fb = 1'b0;
        tick(FLT, 2'd3);
        clear_fault();

        // E-stop and overload together in DELTA; ack refused while run_req held.
        run_to_delta();
        estop = 1'b1; ovl_trip = 1'b1;
        tick(FLT, 2'd1);
        estop = 1'b0; ovl_trip = 1'b0; fault_clr = 1'b1;
        repeat (2) tick(FLT, 2'd1);
        run_req = 1'b0;
        tick(IDLE);
        fault_clr = 1'b0;

        // Overload while idle; ack refused while overload present.
        ovl_trip = 1'b1;
        tick(FLT, 2'd2);
        fault_clr = 1'b1;
        tick(FLT, 2'd2);
        ovl_trip = 1'b0;
        tick(IDLE);
        fault_clr = 1'b0;

        // STAR expiry coincident with e-stop.
        run_req = 1'b1;
        repeat (20) tick(STAR);
        estop = 1'b1;
        tick(FLT, 2'd1);
        clear_fault();

        // ena low for 5 cycles mid-STAR, with run_req dropped meanwhile.
        run_req = 1'b1;
        repeat (10) tick(STAR);
        ena = 1'b0; run_req = 1'b0;
        repeat (5) tick(STAR);
        ena = 1'b1; run_req = 1'b1;
        repeat (10) tick(STAR);
        repeat (4)  tick(DEAD);
        tick(DELTA);

        // Asynchronous reset mid-cycle in DELTA.
        #2;
        rst_n = 1'b0;
        #1;
        check_all(e0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(STAR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
